// File: rtl/dac_addr_gen.sv
// Playback address generator for the DAC sample BRAM: walks start..end in loop or one-shot mode.
// Optional decimation is compiled in with `define ADDR_GEN_DECIM_EN.
module dac_addr_gen #(
  parameter int ADDR_W  = 14,
  parameter int DECIM_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              en,
  input  logic              mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DECIM_W-1:0] decim,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              wrap,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              mode_q, mode_d;
  logic              wrap_q, wrap_d;
  logic              tick;
  logic              xfer;
  logic [ADDR_W-1:0] clamp_end;

  // An inverted window collapses to the single address start_addr.
  assign clamp_end = (end_addr < start_addr) ? start_addr : end_addr;
  assign xfer      = (state_q == S_RUN) && ready && tick;

`ifdef ADDR_GEN_DECIM_EN
  logic [DECIM_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == decim);

  always_comb begin
    cnt_d = cnt_q;
    if (we || !en || state_q == S_LOAD)
      cnt_d = '0;
    else if (state_q == S_RUN && ready)
      cnt_d = tick ? '0 : cnt_q + DECIM_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_decim;
  assign unused_decim = ^decim;
  assign tick         = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    start_d = start_q;
    end_d   = end_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    if (we || !en) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_LOAD;
        S_LOAD: begin
          start_d = start_addr;
          end_d   = clamp_end;
          mode_d  = mode;
          addr_d  = start_addr;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (xfer) begin
            if (addr_q != end_q) begin
              addr_d = addr_q + ADDR_W'(1);
            end else if (!mode_q) begin
              // Window inputs are only sampled here and at LOAD, so a mid-pass update is glitch-free.
              start_d = start_addr;
              end_d   = clamp_end;
              addr_d  = start_addr;
              wrap_d  = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      end_q   <= end_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = (state_q == S_RUN);
  assign busy       = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign wrap       = wrap_q;

endmodule
